// File: rtl/riscv_mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port memory with wait states.
// Optional write protection of the instruction region: define RISCV_MEM_ARB_WPROT_EN.
module riscv_mem_arbiter #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 9,
   parameter int IADDR_W     = 8,
   parameter int IBASE       = 0,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               if_req,
   input  logic [IADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0]  if_rdata,
   output logic               if_ready,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [DATA_W-1:0]  d_wdata,
   output logic [DATA_W-1:0]  d_rdata,
   output logic               d_ready,
   output logic               mem_en,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic               core_stall,
   output logic               err_wprot
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [ADDR_W-1:0] IBASE_A   = ADDR_W'(IBASE);

   state_t            state_reg;
   logic              grant_d_reg;
   logic              last_d_reg;
   logic              store_reg;
   logic              blocked_reg;
   logic [3:0]        cnt_reg;

   logic              if_req_eff;
   logic              d_req_eff;
   logic              pick_d;
   logic              pick_i;
   logic [ADDR_W-1:0] fetch_addr;
   logic              wprot_hit;

   // A requester whose ready is still high is completing, not asking again.
   assign if_req_eff = if_req & ~if_ready;
   assign d_req_eff  = d_req & ~d_ready;
   assign pick_d     = d_req_eff & (~if_req_eff | ~last_d_reg);
   assign pick_i     = if_req_eff & ~pick_d;
   assign fetch_addr = IBASE_A + ADDR_W'(if_addr);

   assign core_stall = (if_req & ~if_ready) | (d_req & ~d_ready);

`ifdef RISCV_MEM_ARB_WPROT_EN
   localparam int              AW1   = ADDR_W + 1;
   localparam logic [ADDR_W:0] WP_LO = AW1'(IBASE);
   localparam logic [ADDR_W:0] WP_HI = AW1'(IBASE + (2 ** IADDR_W));

   // Range compare is one bit wider so the region end never wraps.
   assign wprot_hit = d_we && ({1'b0, d_addr} >= WP_LO) && ({1'b0, d_addr} < WP_HI);
`else
   assign wprot_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         grant_d_reg <= 1'b0;
         last_d_reg  <= 1'b0;
         store_reg   <= 1'b0;
         blocked_reg <= 1'b0;
         cnt_reg     <= 4'd0;
         if_rdata    <= '0;
         d_rdata     <= '0;
         if_ready    <= 1'b0;
         d_ready     <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         err_wprot   <= 1'b0;
      end else begin
         if_ready <= 1'b0;
         d_ready  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick_d) begin
                  grant_d_reg <= 1'b1;
                  store_reg   <= d_we;
                  blocked_reg <= wprot_hit;
                  mem_en      <= ~wprot_hit;
                  mem_we      <= d_we & ~wprot_hit;
                  mem_addr    <= d_addr;
                  mem_wdata   <= d_wdata;
                  cnt_reg     <= WAIT_INIT;
                  state_reg   <= ISSUE;
               end else if (pick_i) begin
                  grant_d_reg <= 1'b0;
                  store_reg   <= 1'b0;
                  blocked_reg <= 1'b0;
                  mem_en      <= 1'b1;
                  mem_we      <= 1'b0;
                  mem_addr    <= fetch_addr;
                  mem_wdata   <= '0;
                  cnt_reg     <= WAIT_INIT;
                  state_reg   <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               mem_addr <= '0;
               if (blocked_reg) begin
                  err_wprot <= 1'b1;
               end
               state_reg <= (WAIT_CYCLES > 0) ? WAIT : DONE;
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg <= 4'd1) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // Stores leave d_rdata untouched.
               if (grant_d_reg) begin
                  d_ready <= 1'b1;
                  if (!store_reg) begin
                     d_rdata <= mem_rdata;
                  end
               end else begin
                  if_ready <= 1'b1;
                  if_rdata <= mem_rdata;
               end
               last_d_reg <= grant_d_reg;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
